// File: rtl/gpio_trig_pulse.sv
// Armed trigger-to-pulse sequencer sitting behind gpio_ctrl, with event counter and overrun flag.
// Optional trigger debounce filter enabled by defining GPIO_TRIG_DEBOUNCE_EN.
module gpio_trig_pulse #(
    parameter int GPIO_REG_WIDTH = 12,
    parameter int TRIG_BIT       = 2,
    parameter int OUT_BIT        = 0,
    parameter int CNT_WIDTH      = 16,
    parameter int DEBOUNCE_LEN   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] gpio_out,
    input  logic                      arm,
    input  logic [CNT_WIDTH-1:0]      delay,
    input  logic [CNT_WIDTH-1:0]      width,
    input  logic                      clear,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_WIDTH-1:0]      trig_count,
    output logic                      overrun
);
    typedef enum logic [1:0] {IDLE, ARMED, DELAY, PULSE} state_t;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx, d_l, w_l;
    logic                 done_nx;
    logic                 trig_s, trig_q, rise;

    // Only TRIG_BIT of gpio_in drives logic; the rest is deliberately ignored.
    logic unused_in;
    assign unused_in = ^{gpio_in, DEBOUNCE_LEN > 0};

`ifdef GPIO_TRIG_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_LEN + 1);
    logic [DB_W-1:0] db_cnt;
    logic            trig_db;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt  <= '0;
            trig_db <= 1'b0;
        end else if (gpio_in[TRIG_BIT] == trig_db) begin
            db_cnt  <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_LEN - 1)) begin
            trig_db <= gpio_in[TRIG_BIT];
            db_cnt  <= '0;
        end else begin
            db_cnt  <= db_cnt + DB_W'(1);
        end
    end

    assign trig_s = trig_db;
`else
    assign trig_s = gpio_in[TRIG_BIT];
`endif

    assign rise = trig_s & ~trig_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            d_l   <= '0;
            w_l   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= done_nx;
            if (state == IDLE && arm) begin
                d_l <= delay;
                w_l <= width;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (arm) state_nx = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    if (d_l != '0) begin
                        state_nx = DELAY;
                        cnt_nx   = d_l - ONE;
                    end else if (w_l != '0) begin
                        state_nx = PULSE;
                        cnt_nx   = w_l - ONE;
                    end else begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    if (w_l != '0) begin
                        state_nx = PULSE;
                        cnt_nx   = w_l - ONE;
                    end else begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decode the state register directly so reset drops them asynchronously.
    always_comb begin
        gpio_out          = '0;
        gpio_out[OUT_BIT] = (state == PULSE);
        busy              = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q     <= 1'b0;
            trig_count <= '0;
            overrun    <= 1'b0;
        end else begin
            trig_q <= trig_s;
            if (clear) begin
                trig_count <= '0;
                overrun    <= 1'b0;
            end else if (rise) begin
                if (trig_count != '1) trig_count <= trig_count + ONE;
                if (state == DELAY || state == PULSE) overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gpio_trig_pulse.sv
// Bench for gpio_trig_pulse: table-driven pulse vectors with a per-cycle scoreboard,
// plus hand sequences for back-to-back arm, mid-pulse reset, saturation and debounce.
module tb_gpio_trig_pulse;
    localparam int W      = 12;
    localparam int CW     = 16;
    localparam int TB_TRIG = 2;
    localparam logic [W-1:0] NOISE  = 12'hAF3;
    localparam logic [W-1:0] OUTVAL = 12'h001;

    logic          clk = 1'b0, reset = 1'b1;
    logic [W-1:0]  gpio_in = NOISE;
    logic [W-1:0]  gpio_out;
    logic          arm = 1'b0, clear = 1'b0;
    logic [CW-1:0] delay = '0, width = '0;
    logic          busy, done, overrun;
    logic [CW-1:0] trig_count;

    logic [3:0]    sat_delay = '0, sat_width = '0;
    logic [W-1:0]  sat_gpio_out;
    logic          sat_busy, sat_done, sat_overrun;
    logic [3:0]    sat_count;

    gpio_trig_pulse #(.GPIO_REG_WIDTH(W), .TRIG_BIT(2), .OUT_BIT(0), .CNT_WIDTH(CW), .DEBOUNCE_LEN(4)) dut (
        .clk(clk), .reset(reset), .gpio_in(gpio_in), .gpio_out(gpio_out), .arm(arm),
        .delay(delay), .width(width), .clear(clear), .busy(busy), .done(done),
        .trig_count(trig_count), .overrun(overrun));

    // Narrow-counter instance so saturation is reachable in a short run.
    gpio_trig_pulse #(.GPIO_REG_WIDTH(W), .TRIG_BIT(2), .OUT_BIT(0), .CNT_WIDTH(4), .DEBOUNCE_LEN(4)) u_sat (
        .clk(clk), .reset(reset), .gpio_in(gpio_in), .gpio_out(sat_gpio_out), .arm(1'b0),
        .delay(sat_delay), .width(sat_width), .clear(clear), .busy(sat_busy), .done(sat_done),
        .trig_count(sat_count), .overrun(sat_overrun));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int            c;
        logic [W-1:0]  g;
        logic          b;
        logic          d;
        logic [CW-1:0] cn;
        logic          ov;
    } exp_t;
    exp_t sb[$];
    exp_t e_m;

    task automatic push_exp(input int c, input logic [W-1:0] g, input logic b, input logic d,
                            input int cn, input logic ov);
        exp_t e;
        e.c = c; e.g = g; e.b = b; e.d = d; e.cn = CW'(cn); e.ov = ov;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].c < cyc) begin
            e_m = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL sb_missed: entry for cycle %0d not compared, now cycle %0d", e_m.c, cyc);
        end
        if (sb.size() > 0 && sb[0].c == cyc) begin
            e_m = sb.pop_front();
            chk("sb_gpio_out", 32'(gpio_out), 32'(e_m.g));
            chk("sb_busy", 32'(busy), 32'(e_m.b));
            chk("sb_done", 32'(done), 32'(e_m.d));
            chk("sb_trig_count", 32'(trig_count), 32'(e_m.cn));
            chk("sb_overrun", 32'(overrun), 32'(e_m.ov));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_trig(input logic t);
        gpio_in = NOISE | (W'(t) << TB_TRIG);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Vector: delay, width, second-edge offset from T (0 = none), expected pulse
    // first/last cycle offsets, done offset, overrun expectation, clear afterwards.
    typedef struct {
        int d, w, off, first, last, dn;
        bit ovr, clr;
    } vec_t;
    vec_t vt[7];

    int base = 0;
    bit ovb  = 1'b0;

    task automatic run_vec(input vec_t v);
        int t, cn;
        logic [W-1:0] g;
        tick(); arm = 1'b1; delay = CW'(v.d); width = CW'(v.w);
        push_exp(cyc, '0, 1'b0, 1'b0, base, ovb);
        tick(); arm = 1'b0;
        push_exp(cyc, '0, 1'b1, 1'b0, base, ovb);
        tick(); set_trig(1'b1); t = cyc;
        for (int r = 0; r <= v.dn + 1; r++) begin
            g  = (r >= v.first && r <= v.last) ? OUTVAL : '0;
            cn = base + ((r >= 1) ? 1 : 0) + ((v.off != 0 && r >= v.off + 1) ? 1 : 0);
            push_exp(t + r, g, r < v.dn, r == v.dn, cn, ovb | (v.ovr && r >= v.off + 1));
        end
        for (int r = 1; r <= v.dn + 1; r++) begin
            tick(); set_trig(v.off != 0 && r == v.off);
        end
        drain();
        base += 1 + ((v.off != 0) ? 1 : 0);
        ovb  |= v.ovr;
        if (v.clr) begin
            tick(); clear = 1'b1;
            tick(); clear = 1'b0;
            push_exp(cyc, '0, 1'b0, 1'b0, 0, 1'b0);
            base = 0; ovb = 1'b0;
            drain();
        end
    endtask

    initial begin
        int t;
        logic [8:0] gv, bv, dv;
        vt[0] = '{3, 5,  0, 4, 8,  9,  1'b0, 1'b0};
        vt[1] = '{0, 0,  0, 1, 0,  1,  1'b0, 1'b0};
        vt[2] = '{2, 10, 5, 3, 12, 13, 1'b1, 1'b1};
        vt[3] = '{0, 1,  0, 1, 1,  2,  1'b0, 1'b0};
        vt[4] = '{1, 0,  0, 1, 0,  2,  1'b0, 1'b0};
        vt[5] = '{0, 3,  2, 1, 3,  4,  1'b1, 1'b0};
        vt[6] = '{4, 2,  3, 5, 6,  7,  1'b1, 1'b1};

        #1 reset = 1'b0;
        #12;
        chk("rst_gpio_out", 32'(gpio_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_trig_count", 32'(trig_count), 0);
        chk("rst_overrun", 32'(overrun), 0);
        @(negedge clk); reset = 1'b1;

`ifdef GPIO_TRIG_DEBOUNCE_EN
        tick(); set_trig(1'b1);
        repeat (3) tick();
        set_trig(1'b0);
        repeat (8) tick();
        chk("db_glitch_count", 32'(trig_count), 0);
        tick(); arm = 1'b1; delay = '0; width = CW'(2);
        tick(); arm = 1'b0;
        tick(); set_trig(1'b1);
        repeat (4) tick();
        chk("db_gpio_t4", 32'(gpio_out), 0);
        tick();
        chk("db_gpio_t5", 32'(gpio_out), 32'(OUTVAL));
        chk("db_count_t5", 32'(trig_count), 1);
        tick();
        chk("db_gpio_t6", 32'(gpio_out), 32'(OUTVAL));
        tick();
        chk("db_gpio_t7", 32'(gpio_out), 0);
        chk("db_done_t7", 32'(done), 1);
        set_trig(1'b0);
`else
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Back-to-back: arm held through done, second trigger at the earliest slot.
        tick(); arm = 1'b1; delay = CW'(1); width = CW'(1);
        push_exp(cyc, '0, 1'b0, 1'b0, base, ovb);
        tick();
        push_exp(cyc, '0, 1'b1, 1'b0, base, ovb);
        tick(); set_trig(1'b1); t = cyc;
        gv = 9'b001000100; bv = 9'b001110111; dv = 9'b010001000;
        for (int r = 0; r <= 8; r++)
            push_exp(t + r, gv[r] ? OUTVAL : '0, bv[r], dv[r],
                     base + ((r >= 1) ? 1 : 0) + ((r >= 5) ? 1 : 0), ovb);
        tick(); set_trig(1'b0);
        tick();
        tick();
        tick(); arm = 1'b0; set_trig(1'b1);
        tick(); set_trig(1'b0);
        drain();
        base += 2;

        // Reset in the middle of a pulse.
        tick(); arm = 1'b1; delay = '0; width = CW'(10);
        tick(); arm = 1'b0;
        tick(); set_trig(1'b1);
        tick(); set_trig(1'b0);
        tick();
        tick();
        chk("pre_rst_gpio_out", 32'(gpio_out), 32'(OUTVAL));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_gpio_out", 32'(gpio_out), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_trig_count", 32'(trig_count), 0);
        @(negedge clk); reset = 1'b1;
        tick(); set_trig(1'b1);
        tick(); set_trig(1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("post_rst_gpio_out", 32'(gpio_out), 0);
            chk("post_rst_busy", 32'(busy), 0);
        end
        chk("post_rst_count", 32'(trig_count), 1);

        // Saturation on the 4-bit instance, then clear colliding with an edge.
        tick(); clear = 1'b1;
        tick(); clear = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick(); set_trig(1'b1);
            tick(); set_trig(1'b0);
        end
        chk("sat15_count", 32'(sat_count), 15);
        chk("main15_count", 32'(trig_count), 15);
        tick(); set_trig(1'b1);
        tick(); set_trig(1'b0);
        chk("sat16_count", 32'(sat_count), 15);
        chk("main16_count", 32'(trig_count), 16);
        chk("sat_idle_outs", 32'({sat_gpio_out, sat_busy, sat_done, sat_overrun}), 0);
        tick(); clear = 1'b1; set_trig(1'b1);
        tick(); clear = 1'b0; set_trig(1'b0);
        chk("clr_edge_main_count", 32'(trig_count), 0);
        chk("clr_edge_sat_count", 32'(sat_count), 0);
        chk("clr_edge_overrun", 32'(overrun), 0);
`endif
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end
endmodule
